amp_pair_sequencer: RTL and testbench

//  Sweeps the state-vector RAM for one single-qubit X/Z operation on a chosen target qubit.

---
 rtl/amp_pair_sequencer_if.sv | 52 +++++
 rtl/amp_pair_sequencer.sv | 174 +++++++++++++++++
 tb/tb_amp_pair_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_pair_sequencer_if.sv
// RAM and gate-stage bus of the amplitude pair sequencer.
// master = sequencer, slave = amplitude RAM plus X/Z gate stage.
interface amp_pair_sequencer_if #(
  parameter int NQ = 3
);
  logic               rd_en;
  logic [NQ-1:0]      rd_addr0;
  logic [NQ-1:0]      rd_addr1;
  logic signed [15:0] rd_d0r;
  logic signed [15:0] rd_d0i;
  logic signed [15:0] rd_d1r;
  logic signed [15:0] rd_d1i;

  logic               g_x;
  logic               g_z;
  logic signed [15:0] g_in0r;
  logic signed [15:0] g_in0i;
  logic signed [15:0] g_in1r;
  logic signed [15:0] g_in1i;
  logic signed [15:0] g_out0r;
  logic signed [15:0] g_out0i;
  logic signed [15:0] g_out1r;
  logic signed [15:0] g_out1i;

  logic               wr_en;
  logic [NQ-1:0]      wr_addr0;
  logic [NQ-1:0]      wr_addr1;
  logic signed [15:0] wr_d0r;
  logic signed [15:0] wr_d0i;
  logic signed [15:0] wr_d1r;
  logic signed [15:0] wr_d1i;

  modport master (
    output rd_en, rd_addr0, rd_addr1,
    input  rd_d0r, rd_d0i, rd_d1r, rd_d1i,
    output g_x, g_z,
    output g_in0r, g_in0i, g_in1r, g_in1i,
    input  g_out0r, g_out0i, g_out1r, g_out1i,
    output wr_en, wr_addr0, wr_addr1,
    output wr_d0r, wr_d0i, wr_d1r, wr_d1i
  );

  modport slave (
    input  rd_en, rd_addr0, rd_addr1,
    output rd_d0r, rd_d0i, rd_d1r, rd_d1i,
    input  g_x, g_z,
    input  g_in0r, g_in0i, g_in1r, g_in1i,
    output g_out0r, g_out0i, g_out1r, g_out1i,
    input  wr_en, wr_addr0, wr_addr1,
    input  wr_d0r, wr_d0i, wr_d1r, wr_d1i
  );
endinterface

// File: rtl/amp_pair_sequencer.sv
// Amplitude pair sweep for one X/Z op on a target qubit, 1 pair/clk.
// Optional SEQ_STATS_EN adds a saturating sweep_cnt of good sweeps.
module amp_pair_sequencer #(
  parameter int NQ = 3,
  parameter int QW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] target,
  input  logic          op_x,
  input  logic          op_z,
  output logic          busy,
  output logic          done,
  output logic          err,
`ifdef SEQ_STATS_EN
  output logic [15:0]   sweep_cnt,
`endif
  amp_pair_sequencer_if.master bus
);

  localparam int PW = NQ - 1;
  localparam int NP = 2 ** PW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [QW-1:0] t_q, t_d;
  logic          x_q, x_d;
  logic          z_q, z_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic [NQ-1:0] wa0_q, wa0_d;
  logic [NQ-1:0] wa1_q, wa1_d;

  logic [NQ-1:0] pe;
  logic [NQ-1:0] lo_m;
  logic [NQ-1:0] a0;
  logic [NQ-1:0] a1;
  logic          rd_en;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    x_d     = x_q;
    z_d     = z_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          t_d = target;
          x_d = op_x;
          z_d = op_z;
          p_d = '0;
          if ({1'b0, target} >= (QW+1)'(NQ)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        p_d = p_q + PW'(1);
        if (p_q == PW'(NP - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // insert a 0 at bit t of p by shifting the bits at and above t up by one
  always_comb begin
    pe   = NQ'(p_q);
    lo_m = (NQ'(1) << t_q) - NQ'(1);
    a0   = ((pe & ~lo_m) << 1) | (pe & lo_m);
    a1   = a0 | (NQ'(1) << t_q);
  end

  assign rd_en = (state_q == S_RUN);

  always_comb begin
    vld_d = rd_en;
    wa0_d = rd_en ? a0 : '0;
    wa1_d = rd_en ? a1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      t_q     <= '0;
      x_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      wa0_q   <= '0;
      wa1_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      t_q     <= t_d;
      x_q     <= x_d;
      z_q     <= z_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
  assign err  = done & err_q;

  assign bus.rd_en    = rd_en;
  assign bus.rd_addr0 = rd_en ? a0 : '0;
  assign bus.rd_addr1 = rd_en ? a1 : '0;

  assign bus.g_x    = x_q;
  assign bus.g_z    = z_q;
  assign bus.g_in0r = bus.rd_d0r;
  assign bus.g_in0i = bus.rd_d0i;
  assign bus.g_in1r = bus.rd_d1r;
  assign bus.g_in1i = bus.rd_d1i;

  assign bus.wr_en    = vld_q;
  assign bus.wr_addr0 = wa0_q;
  assign bus.wr_addr1 = wa1_q;
  assign bus.wr_d0r   = bus.g_out0r;
  assign bus.wr_d0i   = bus.g_out0i;
  assign bus.wr_d1r   = bus.g_out1r;
  assign bus.wr_d1i   = bus.g_out1i;

`ifdef SEQ_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done && !err_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sweep_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_amp_pair_sequencer.sv
// Directed bench: 8-entry RAM with 1-cycle read and an X/Z gate model.
// Z is applied before X when both are selected.
module tb_amp_pair_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] target;
  logic       op_x;
  logic       op_z;
  logic       busy;
  logic       done;
  logic       err;
`ifdef SEQ_STATS_EN
  logic [15:0] sweep_cnt;
`endif

  amp_pair_sequencer_if #(.NQ(3)) bus ();

  amp_pair_sequencer #(.NQ(3), .QW(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .op_x   (op_x),
    .op_z   (op_z),
    .busy   (busy),
    .done   (done),
    .err    (err),
`ifdef SEQ_STATS_EN
    .sweep_cnt (sweep_cnt),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] ram_r [8];
  logic signed [15:0] ram_i [8];
  logic signed [15:0] pre_r [8];
  logic signed [15:0] pre_i [8];
  logic               ld;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++) begin
        ram_r[i] <= pre_r[i];
        ram_i[i] <= pre_i[i];
      end
    end else begin
      if (bus.rd_en) begin
        bus.rd_d0r <= ram_r[bus.rd_addr0];
        bus.rd_d0i <= ram_i[bus.rd_addr0];
        bus.rd_d1r <= ram_r[bus.rd_addr1];
        bus.rd_d1i <= ram_i[bus.rd_addr1];
      end
      if (bus.wr_en) begin
        ram_r[bus.wr_addr0] <= bus.wr_d0r;
        ram_i[bus.wr_addr0] <= bus.wr_d0i;
        ram_r[bus.wr_addr1] <= bus.wr_d1r;
        ram_i[bus.wr_addr1] <= bus.wr_d1i;
      end
    end
  end

  logic signed [15:0] z1r, z1i;

  always_comb begin
    z1r = bus.g_z ? -bus.g_in1r : bus.g_in1r;
    z1i = bus.g_z ? -bus.g_in1i : bus.g_in1i;
    if (bus.g_x) begin
      bus.g_out0r = z1r;
      bus.g_out0i = z1i;
      bus.g_out1r = bus.g_in0r;
      bus.g_out1i = bus.g_in0i;
    end else begin
      bus.g_out0r = bus.g_in0r;
      bus.g_out0i = bus.g_in0i;
      bus.g_out1r = z1r;
      bus.g_out1i = z1i;
    end
  end

  int         n_rd = 0;
  int         n_wr = 0;
  int         n_busy = 0;
  int         n_done = 0;
  logic [2:0] log_a0 [64];
  logic [2:0] log_a1 [64];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      log_a0[n_rd % 64] <= bus.rd_addr0;
      log_a1[n_rd % 64] <= bus.rd_addr1;
      n_rd <= n_rd + 1;
    end
    if (bus.wr_en) n_wr <= n_wr + 1;
    if (busy) n_busy <= n_busy + 1;
    if (done) n_done <= n_done + 1;
  end

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic load();
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] tg, input logic x,
                        input logic z, output int cyc, output logic e);
    start  = 1'b1;
    target = tg;
    op_x   = x;
    op_z   = z;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    e   = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      if (done) begin
        e = err;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic signed [15:0] exp3 [8] = '{-16'sd2, -16'sd3, 16'sd0, 16'sd1,
                                   -16'sd6, -16'sd7, 16'sd4, 16'sd5};
  logic [2:0] ord0 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
  logic [2:0] ord1 [4] = '{3'd2, 3'd3, 3'd6, 3'd7};

  int   cyc;
  logic e;
  int   b_rd, b_wr, b_busy, b_done;

  task automatic snap();
    b_rd   = n_rd;
    b_wr   = n_wr;
    b_busy = n_busy;
    b_done = n_done;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    target = '0;
    op_x = 1'b0;
    op_z = 1'b0;
    ld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pre_r[i] = '0;
      pre_i[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_rd_en", 16'(bus.rd_en), 16'd0);
    chk("rst_wr_en", 16'(bus.wr_en), 16'd0);
    chk("rst_rd_addr0", 16'(bus.rd_addr0), 16'd0);
    chk("rst_rd_addr1", 16'(bus.rd_addr1), 16'd0);
    chk("rst_wr_addr0", 16'(bus.wr_addr0), 16'd0);
    rst = 1'b0;
    load();

    pre_r[0] = 16'sh4000;
    load();
    snap();
    run_op(2'd0, 1'b1, 1'b0, cyc, e);
    chk("x_t0_cyc", 16'(cyc), 16'd6);
    chk("x_t0_err", 16'(e), 16'd0);
    chk("x_t0_ram0", ram_r[0], 16'h0000);
    chk("x_t0_ram1", ram_r[1], 16'h4000);
    chk("x_t0_nrd", 16'(n_rd - b_rd), 16'd4);
    chk("x_t0_nwr", 16'(n_wr - b_wr), 16'd4);
    chk("x_t0_busy", 16'(n_busy - b_busy), 16'd6);

    for (int i = 0; i < 8; i++) begin
      pre_r[i] = 16'sh1000;
      pre_i[i] = 16'sh1000;
    end
    load();
    run_op(2'd2, 1'b0, 1'b1, cyc, e);
    chk("z_t2_cyc", 16'(cyc), 16'd6);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("z_t2_re%0d", i), ram_r[i],
          (i >= 4) ? 16'hF000 : 16'h1000);
      chk($sformatf("z_t2_im%0d", i), ram_i[i],
          (i >= 4) ? 16'hF000 : 16'h1000);
    end

    for (int i = 0; i < 8; i++) begin
      pre_r[i] = 16'(i);
      pre_i[i] = '0;
    end
    load();
    snap();
    run_op(2'd1, 1'b1, 1'b1, cyc, e);
    chk("xz_t1_cyc", 16'(cyc), 16'd6);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("xz_t1_a0_%0d", k), 16'(log_a0[(b_rd + k) % 64]),
          16'(ord0[k]));
      chk($sformatf("xz_t1_a1_%0d", k), 16'(log_a1[(b_rd + k) % 64]),
          16'(ord1[k]));
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("xz_t1_re%0d", i), ram_r[i], exp3[i]);
    end

    snap();
    run_op(2'd3, 1'b1, 1'b0, cyc, e);
    chk("rej_cyc", 16'(cyc), 16'd1);
    chk("rej_err", 16'(e), 16'd1);
    chk("rej_nrd", 16'(n_rd - b_rd), 16'd0);
    chk("rej_nwr", 16'(n_wr - b_wr), 16'd0);
    chk("rej_busy", 16'(n_busy - b_busy), 16'd1);

    snap();
    start = 1'b1;
    target = 2'd0;
    op_x = 1'b0;
    op_z = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    target = 2'd3;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 40 && !done) begin
      @(negedge clk);
      cyc++;
    end
    chk("rep_done_cyc", 16'(cyc), 16'd4);
    chk("rep_err", 16'(err), 16'd0);
    start = 1'b1;
    target = 2'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("fin_start_busy", 16'(busy), 16'd0);
    repeat (8) @(negedge clk);
    chk("rep_ndone", 16'(n_done - b_done), 16'd1);
    chk("rep_nwr", 16'(n_wr - b_wr), 16'd4);

    snap();
    start = 1'b1;
    target = 2'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_wr_en", 16'(bus.wr_en), 16'd0);
    chk("mrst_rd_en", 16'(bus.rd_en), 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0);
    repeat (8) @(negedge clk);
    chk("mrst_ndone", 16'(n_done - b_done), 16'd0);
    run_op(2'd0, 1'b1, 1'b0, cyc, e);
    chk("mrst_new_cyc", 16'(cyc), 16'd6);

`ifdef SEQ_STATS_EN
    run_op(2'd1, 1'b0, 1'b1, cyc, e);
    run_op(2'd3, 1'b0, 1'b0, cyc, e);
    run_op(2'd2, 1'b1, 1'b1, cyc, e);
    chk("sweep_cnt", sweep_cnt, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
